// File: rtl/knap_subset_search.sv
// knap_subset_search: exhaustive knapsack search over all item subsets in Gray order.
// Build option KNAP_SEARCH_ABORT_EN adds an abort input and an aborted flag.
module knap_subset_search #(
    parameter int N_ITEMS = 7,
    parameter int VAL_W   = 16,
    parameter int WT_W    = 16,
    parameter int ACC_W   = 32,
    localparam int AW     = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [VAL_W-1:0]   cfg_value,
    input  logic [WT_W-1:0]    cfg_weight,
    input  logic [ACC_W-1:0]   min_value,
    input  logic [ACC_W-1:0]   max_weight,
    input  logic               start,
`ifdef KNAP_SEARCH_ABORT_EN
    input  logic               abort,
    output logic               aborted,
`endif
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic [N_ITEMS-1:0] best_mask,
    output logic [ACC_W-1:0]   best_value,
    output logic [ACC_W-1:0]   best_weight,
    output logic [N_ITEMS:0]   valid_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_SCAN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [VAL_W-1:0]   r_val [N_ITEMS];
    logic [WT_W-1:0]    r_wt  [N_ITEMS];
    logic [ACC_W-1:0]   r_min;
    logic [ACC_W-1:0]   r_max;
    logic [ACC_W-1:0]   r_tot_v;
    logic [ACC_W-1:0]   r_tot_w;
    logic [N_ITEMS-1:0] r_mask;
    logic [N_ITEMS-1:0] r_k;
    logic [N_ITEMS-1:0] r_best_mask;
    logic [ACC_W-1:0]   r_best_v;
    logic [ACC_W-1:0]   r_best_w;
    logic               r_found;
    logic [N_ITEMS:0]   r_cnt;

    logic [N_ITEMS-1:0] w_kp1;
    logic [AW-1:0]      w_j;
    logic [ACC_W-1:0]   w_item_v;
    logic [ACC_W-1:0]   w_item_w;
    logic               w_abort;
    logic               w_busy;
    logic               w_valid;
    logic               w_better;
    logic               w_last;
    logic               w_eval;
    logic               w_cfg_ok;

`ifdef KNAP_SEARCH_ABORT_EN
    logic r_aborted;
    assign w_abort = abort;
    assign aborted = r_aborted;
`else
    assign w_abort = 1'b0;
`endif

    assign w_busy   = (r_state == S_INIT) || (r_state == S_SCAN);
    assign w_last   = &r_k;
    assign w_kp1    = r_k + N_ITEMS'(1);
    assign w_eval   = (r_state == S_SCAN) && !w_abort;
    assign w_item_v = ACC_W'(r_val[w_j]);
    assign w_item_w = ACC_W'(r_wt[w_j]);
    assign w_cfg_ok = cfg_we && !w_busy && (int'(cfg_addr) < N_ITEMS);

    assign w_valid  = (r_tot_v >= r_min) && (r_tot_w <= r_max);
    // Strictly better only; a full tie keeps the subset found first.
    assign w_better = w_valid && (!r_found || (r_tot_v > r_best_v) ||
                      ((r_tot_v == r_best_v) && (r_tot_w < r_best_w)));

    // Gray step: the bit to flip is the lowest set bit of k+1.
    always_comb begin
        w_j = '0;
        for (int i = N_ITEMS - 1; i >= 0; i--) begin
            if (w_kp1[i]) w_j = AW'(i);
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (start) w_next = S_INIT;
            S_INIT: w_next = w_abort ? S_DONE : S_SCAN;
            S_SCAN: if (w_abort || w_last) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ITEMS; i++) begin
                r_val[i] <= '0;
                r_wt[i]  <= '0;
            end
        end else if (w_cfg_ok) begin
            r_val[cfg_addr] <= cfg_value;
            r_wt[cfg_addr]  <= cfg_weight;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_min       <= '0;
            r_max       <= '0;
            r_tot_v     <= '0;
            r_tot_w     <= '0;
            r_mask      <= '0;
            r_k         <= '0;
            r_best_mask <= '0;
            r_best_v    <= '0;
            r_best_w    <= '0;
            r_found     <= 1'b0;
            r_cnt       <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_min <= min_value;
                        r_max <= max_weight;
                    end
                end
                S_INIT: begin
                    r_tot_v     <= '0;
                    r_tot_w     <= '0;
                    r_mask      <= '0;
                    r_k         <= '0;
                    r_best_mask <= '0;
                    r_best_v    <= '0;
                    r_best_w    <= '0;
                    r_found     <= 1'b0;
                    r_cnt       <= '0;
                end
                S_SCAN: begin
                    if (w_eval) begin
                        if (w_valid) r_cnt <= r_cnt + (N_ITEMS+1)'(1);
                        if (w_better) begin
                            r_best_mask <= r_mask;
                            r_best_v    <= r_tot_v;
                            r_best_w    <= r_tot_w;
                            r_found     <= 1'b1;
                        end
                        if (!w_last) begin
                            r_k         <= w_kp1;
                            r_mask[w_j] <= ~r_mask[w_j];
                            if (r_mask[w_j]) begin
                                r_tot_v <= r_tot_v - w_item_v;
                                r_tot_w <= r_tot_w - w_item_w;
                            end else begin
                                r_tot_v <= r_tot_v + w_item_v;
                                r_tot_w <= r_tot_w + w_item_w;
                            end
                        end
                    end
                end
                S_DONE: ;
            endcase
        end
    end

`ifdef KNAP_SEARCH_ABORT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    r_aborted <= 1'b0;
        else if (r_state == S_INIT)    r_aborted <= w_abort;
        else if (r_state == S_SCAN &&
                 w_abort)              r_aborted <= 1'b1;
    end
`endif

    assign busy        = w_busy;
    assign done        = (r_state == S_DONE);
    assign found       = r_found;
    assign best_mask   = r_best_mask;
    assign best_value  = r_best_v;
    assign best_weight = r_best_w;
    assign valid_count = r_cnt;

endmodule

// File: tb/tb_knap_subset_search.sv
// tb_knap_subset_search: scoreboard bench for knap_subset_search (N=7 and N=2).
// Abort checks are compiled in with KNAP_SEARCH_ABORT_EN.
module tb_knap_subset_search;

    typedef struct {
        logic        found;
        logic [6:0]  mask;
        logic [31:0] bv;
        logic [31:0] bw;
        logic [7:0]  cnt;
        int          lat;
        logic        ab;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        cfg_we, cfg2_we;
    logic [2:0]  cfg_addr;
    logic [0:0]  cfg2_addr;
    logic [15:0] cfg_value, cfg_weight, cfg2_value, cfg2_weight;
    logic [31:0] min_value, max_weight, min2, max2;
    logic        start, start2;
    logic        busy, done, found, busy2, done2, found2;
    logic [6:0]  best_mask;
    logic [1:0]  best_mask2;
    logic [31:0] best_value, best_weight, best_value2, best_weight2;
    logic [7:0]  valid_count;
    logic [2:0]  valid_count2;
`ifdef KNAP_SEARCH_ABORT_EN
    logic abort, aborted, abort2, aborted2;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   cyc_acc = 0;
    int   cyc_acc2 = 0;
    int   n_done = 0;
    int   d0;
    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;

    logic [15:0] m_v  [7];
    logic [15:0] m_w  [7];
    logic [15:0] m2_v [7];
    logic [15:0] m2_w [7];
    logic [15:0] va   [7] = '{4, 2, 2, 1, 10, 12, 10};
    logic [15:0] wa   [7] = '{12, 1, 2, 1, 4, 2, 2};

    knap_subset_search u_dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_value(cfg_value), .cfg_weight(cfg_weight),
        .min_value(min_value), .max_weight(max_weight),
        .start(start),
`ifdef KNAP_SEARCH_ABORT_EN
        .abort(abort), .aborted(aborted),
`endif
        .busy(busy), .done(done), .found(found),
        .best_mask(best_mask), .best_value(best_value),
        .best_weight(best_weight), .valid_count(valid_count)
    );

    knap_subset_search #(.N_ITEMS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg2_we), .cfg_addr(cfg2_addr),
        .cfg_value(cfg2_value), .cfg_weight(cfg2_weight),
        .min_value(min2), .max_weight(max2),
        .start(start2),
`ifdef KNAP_SEARCH_ABORT_EN
        .abort(abort2), .aborted(aborted2),
`endif
        .busy(busy2), .done(done2), .found(found2),
        .best_mask(best_mask2), .best_value(best_value2),
        .best_weight(best_weight2), .valid_count(valid_count2)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference: sums recomputed from scratch for each Gray mask.
    function automatic exp_t model(input int n, input int lim,
                                   input logic [15:0] v [7],
                                   input logic [15:0] w [7],
                                   input logic [31:0] mn,
                                   input logic [31:0] mx,
                                   input logic ab);
        exp_t e;
        e.found = 1'b0; e.mask = '0; e.bv = '0; e.bw = '0; e.cnt = '0;
        e.ab = ab;
        e.lat = ab ? lim + 2 : (1 << n) + 1;
        for (int k = 0; k < lim; k++) begin
            int g;
            logic [31:0] sv, sw;
            g = k ^ (k >> 1);
            sv = '0; sw = '0;
            for (int i = 0; i < n; i++) begin
                if (g[i]) begin
                    sv = sv + 32'(v[i]);
                    sw = sw + 32'(w[i]);
                end
            end
            if (sv >= mn && sw <= mx) begin
                e.cnt++;
                if (!e.found || sv > e.bv || (sv == e.bv && sw < e.bw)) begin
                    e.found = 1'b1; e.mask = 7'(g); e.bv = sv; e.bw = sw;
                end
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            n_done++;
            chk("sb1_avail", q1.size() != 0, 1);
            if (q1.size() != 0) begin
                e1 = q1.pop_front();
                chk("found", found, e1.found);
                chk("mask", best_mask, e1.mask);
                chk("bval", best_value, e1.bv);
                chk("bwt", best_weight, e1.bw);
                chk("count", valid_count, e1.cnt);
                chk("latency", cyc - cyc_acc, e1.lat);
`ifdef KNAP_SEARCH_ABORT_EN
                chk("aborted", aborted, e1.ab);
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done2) begin
            chk("sb2_avail", q2.size() != 0, 1);
            if (q2.size() != 0) begin
                e2 = q2.pop_front();
                chk("n2_found", found2, e2.found);
                chk("n2_mask", 7'(best_mask2), e2.mask);
                chk("n2_bval", best_value2, e2.bv);
                chk("n2_bwt", best_weight2, e2.bw);
                chk("n2_count", 8'(valid_count2), e2.cnt);
                chk("n2_latency", cyc - cyc_acc2, e2.lat);
`ifdef KNAP_SEARCH_ABORT_EN
                chk("n2_aborted", aborted2, 1'b0);
`endif
            end
        end
    end

    task automatic load(input logic [15:0] v [7], input logic [15:0] w [7]);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            cfg_we = 1'b1; cfg_addr = 3'(i);
            cfg_value = v[i]; cfg_weight = w[i];
            m_v[i] = v[i]; m_w[i] = w[i];
        end
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // lim < 0: start without expecting a result.
    task automatic scan(input logic [31:0] mn, input logic [31:0] mx,
                        input bit hold, input int lim);
        @(negedge clk);
        min_value = mn; max_weight = mx; start = 1'b1;
        if (lim >= 0)
            q1.push_back(model(7, lim, m_v, m_w, mn, mx, lim != 128));
        @(negedge clk);
        cyc_acc = cyc;
        if (!hold) start = 1'b0;
        chk("busy_acc", busy, 1);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", done, 1);
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic load2(input logic [15:0] v0, input logic [15:0] v1,
                         input logic [15:0] w0, input logic [15:0] w1);
        @(negedge clk);
        cfg2_we = 1'b1; cfg2_addr = 1'b0; cfg2_value = v0; cfg2_weight = w0;
        @(negedge clk);
        cfg2_addr = 1'b1; cfg2_value = v1; cfg2_weight = w1;
        @(negedge clk);
        cfg2_we = 1'b0;
        m2_v[0] = v0; m2_v[1] = v1; m2_w[0] = w0; m2_w[1] = w1;
    endtask

    task automatic scan2(input logic [31:0] mn, input logic [31:0] mx);
        int t;
        @(negedge clk);
        min2 = mn; max2 = mx; start2 = 1'b1;
        q2.push_back(model(2, 4, m2_v, m2_w, mn, mx, 1'b0));
        @(negedge clk);
        cyc_acc2 = cyc;
        start2 = 1'b0;
        chk("n2_busy_acc", busy2, 1);
        t = 0;
        while (!done2 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("n2_done_seen", done2, 1);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_value = '0; cfg_weight = '0;
        cfg2_we = 1'b0; cfg2_addr = '0; cfg2_value = '0; cfg2_weight = '0;
        min_value = '0; max_weight = '0; min2 = '0; max2 = '0;
`ifdef KNAP_SEARCH_ABORT_EN
        abort = 1'b0; abort2 = 1'b0;
`endif
        for (int i = 0; i < 7; i++) begin
            m_v[i] = '0; m_w[i] = '0; m2_v[i] = '0; m2_w[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_found", found, 0);
        chk("rst_mask", best_mask, 0);
        chk("rst_bval", best_value, 0);
        chk("rst_bwt", best_weight, 0);
        chk("rst_count", valid_count, 0);
        rst_n = 1'b1;

        load(va, wa);
        scan(15, 16, 0, 128); wait_done();
        chk("base_mask", best_mask, 7'h7E);
        chk("base_bval", best_value, 37);
        chk("base_bwt", best_weight, 12);

        scan(100, 16, 0, 128); wait_done();
        chk("unreach_found", found, 0);
        chk("unreach_count", valid_count, 0);

        scan(0, 1000, 0, 128); wait_done();
        scan(0, 0, 0, 128); wait_done();

        d0 = n_done;
        scan(15, 16, 1, 128);
        repeat (20) @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_value = 16'd50; cfg_weight = 16'd0;
        min_value = 32'd0;
        @(negedge clk);
        cfg_we = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);
        chk("one_done", n_done - d0, 1);
        chk("idle_busy", busy, 0);

        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 3'd7; cfg_value = 16'd99; cfg_weight = 16'd0;
        @(negedge clk);
        cfg_we = 1'b0;
        scan(15, 16, 0, 128); wait_done();

        scan(15, 16, 0, -1);
        repeat (41) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_found", found, 0);
        chk("mid_rst_mask", best_mask, 0);
        chk("mid_rst_bval", best_value, 0);
        chk("mid_rst_bwt", best_weight, 0);
        chk("mid_rst_count", valid_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            m_v[i] = '0; m_w[i] = '0;
        end
        scan(0, 0, 0, 128); wait_done();
        load(va, wa);
        scan(15, 16, 0, 128); wait_done();

`ifdef KNAP_SEARCH_ABORT_EN
        scan(15, 16, 0, 10);
        repeat (11) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done();
        scan(15, 16, 0, 128); wait_done();
`endif

        load2(16'd5, 16'd5, 16'd3, 16'd2);
        scan2(1, 3);
        chk("tie_mask_a", best_mask2, 2'b10);
        chk("tie_bwt_a", best_weight2, 2);
        chk("tie_count_a", valid_count2, 2);
        load2(16'd5, 16'd5, 16'd2, 16'd2);
        scan2(1, 3);
        chk("tie_mask_b", best_mask2, 2'b01);

        repeat (5) @(negedge clk);
        chk("q1_left", q1.size(), 0);
        chk("q2_left", q2.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/knap_subset_search.md
Name: knap_subset_search

Overview:
- Parametrised sequential successor to the team's fixed 7-item combinational knapsack validity checker.
- Holds a loadable table of N_ITEMS (value, weight) pairs.
- On start, walks all 2^N_ITEMS subsets in Gray-code order, one subset per clock.
- Reports the best valid subset (max value subject to min_value/max_weight) and the count of valid subsets. Feeds the solution-checking harness.

Parameters:
N_ITEMS, 7, number of items; mask bit i = item i (bit 0 = first item)
VAL_W, 16, item value width (unsigned)
WT_W, 16, item weight width (unsigned)
ACC_W, 32, accumulator/threshold width; must be >= max(VAL_W,WT_W)+clog2(N_ITEMS)+1

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
cfg_we  input  1  item table write strobe
cfg_addr  input  max(1,clog2(N_ITEMS))  item index to write
cfg_value  input  VAL_W  item value
cfg_weight  input  WT_W  item weight
min_value  input  ACC_W  minimum total value threshold
max_weight  input  ACC_W  maximum total weight threshold
start  input  1  begin search (level-sampled in IDLE)
busy  output  1  high in INIT and SCAN
done  output  1  one-cycle pulse when results are final
found  output  1  at least one valid subset exists
best_mask  output  N_ITEMS  best valid subset
best_value  output  ACC_W  total value of best_mask
best_weight  output  ACC_W  total weight of best_mask
valid_count  output  N_ITEMS+1  number of valid subsets, empty set included

Behaviour:
- Reset (async, rst_n=0): state=IDLE; item table all zero; all outputs 0. Reset mid-scan aborts immediately with no partial result.
- States:
  - IDLE: start=1 -> INIT; latches min_value/max_weight into internal regs.
  - INIT (1 cycle): clears mask, tot_v, tot_w, k, best_*, found, valid_count -> SCAN.
  - SCAN (2^N_ITEMS cycles): each cycle evaluates the current mask.
  - DONE (1 cycle): done=1 -> IDLE.
- Evaluate in each SCAN cycle:
  - valid = (tot_v >= min_lat) && (tot_w <= max_lat), unsigned compare.
  - If valid: valid_count += 1.
  - If valid and (!found || tot_v > best_value || (tot_v == best_value && tot_w < best_weight)): update best_*; found=1. Full tie keeps the earlier subset.
- Advance: toggled bit j = count of trailing zeros of k+1. tot_v/tot_w add item j's value/weight if the bit goes 0->1, subtract if 1->0. k increments. After k = 2^N_ITEMS-1 is evaluated -> DONE.
- Enumeration order starts at the empty mask; the empty set is evaluated first and is valid when min_value=0.
- Latency: start seen at edge t -> busy from t+1 -> done high in cycle t+2+2^N_ITEMS. Total start-to-done is 2^N_ITEMS+2 cycles.
- Result outputs hold from DONE until the next accepted start clears them in INIT.
- Ignored inputs:
  - start while busy or in DONE.
  - cfg_we while busy. Writes in IDLE/DONE take effect next cycle.
  - cfg_addr >= N_ITEMS.
- Threshold inputs may change during a scan without effect.
- Arithmetic: zero-extend items to ACC_W; no overflow by construction of ACC_W; totals never negative.

Optional Feature:
- Macro KNAP_SEARCH_ABORT_EN.
- Defined:
  - Adds input abort (1 bit) and output aborted (1 bit, reset 0).
  - abort=1 in INIT/SCAN -> DONE next cycle; aborted=1 with done; results are partial (subsets evaluated so far).
  - aborted clears in the next INIT.
  - abort in IDLE/DONE is ignored.
- Undefined: neither port exists; scans always complete.

Test Plan:
- Baseline scan, N_ITEMS=7:
  - Stimulus: values {4,2,2,1,10,12,10}, weights {12,1,2,1,4,2,2}, min 15, max 16, start.
  - Required: found=1, best_mask=7'h7E, best_value=37, best_weight=12; valid_count matches reference model.
- Unreachable threshold: same table, min_value=100 -> found=0, best_mask=0, best_value=0, valid_count=0; done still after 130 cycles.
- Tie-break: N_ITEMS=2, values {5,5}, weights {3,2}, min 1, max 3.
  - Required: best_mask=2'b10, best_weight=2, valid_count=2.
  - Then weights {2,2} -> best_mask=2'b01 (first found in Gray order).
- Timing/protocol:
  - start held high across the scan -> exactly one done 130 cycles after acceptance.
  - cfg_we during SCAN does not alter results.
  - min_value change mid-scan ignored.
- Reset mid-scan: rst_n low at SCAN cycle 40 -> all outputs 0 and table cleared immediately. Reload plus restart gives baseline results.
- Abort (KNAP_SEARCH_ABORT_EN): abort at SCAN cycle 10 -> done and aborted next cycle; valid_count equals model over the first 10 Gray subsets.
